// File: rtl/ibex_pkg.sv
// ibex_pkg
// Shared definitions for the instruction-fetch slice: redirect target
// encodings (identical to the controller), the fetch FSM state type, the
// buffered response entry, and the default debug-module entry addresses.
package ibex_pkg;

    typedef enum logic [2:0] {
        PC_BOOT = 3'd0,
        PC_JUMP = 3'd1,
        PC_EXC  = 3'd2,
        PC_ERET = 3'd3,
        PC_DRET = 3'd4
    } pc_sel_e;

    typedef enum logic [1:0] {
        EXC_PC_EXC     = 2'd0,
        EXC_PC_IRQ     = 2'd1,
        EXC_PC_DBD     = 2'd2,
        EXC_PC_DBG_EXC = 2'd3
    } exc_pc_sel_e;

    typedef enum logic {
        FETCH_IDLE = 1'b0,
        FETCH_REQ  = 1'b1
    } fetch_state_e;

    localparam logic [31:0] DM_HALT_ADDR_DEFAULT = 32'h1A11_0800;
    localparam logic [31:0] DM_EXC_ADDR_DEFAULT  = 32'h1A11_0808;

    // One buffered bus response together with the PC it belongs to.
    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic [31:0] pc;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/ibex_fetch_unit_if.sv
// ibex_fetch_unit_if
// Instruction bus between the fetch unit (master) and memory (slave).
//   req    master->slave  request valid, held until gnt
//   addr   master->slave  word address
//   gnt    slave->master  request accepted
//   rvalid slave->master  response valid (in request order)
//   rdata  slave->master  response data
//   err    slave->master  response carries a bus error
interface ibex_fetch_unit_if;
    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output req, addr,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, addr,
        output gnt, rvalid, rdata, err
    );
endinterface

// File: rtl/ibex_fetch_fifo.sv
// ibex_fetch_fifo
// Small circular buffer holding fetched instructions until ID takes them.
// Ports:
//   clk_i, rst_ni  clock, async active-low reset
//   flush_i        drop all entries (wins over push/pop)
//   push_i/push_data_i  write one entry (ignored when full)
//   pop_i          remove the head entry (ignored when empty)
//   pop_data_o     head entry, valid when !empty_o
//   count_o        number of stored entries
//   empty_o        no entries stored
module ibex_fetch_fifo
    import ibex_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             push_i,
    input  fetch_entry_t     push_data_i,
    input  logic             pop_i,
    output fetch_entry_t     pop_data_o,
    output logic [CNT_W-1:0] count_o,
    output logic             empty_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             push_ok, pop_ok;

    function automatic logic [PTR_W-1:0] ptr_inc(logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    assign push_ok = push_i && (count_q != FULL_CNT);
    assign pop_ok  = pop_i && (count_q != '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (pop_ok) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            count_q <= count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

    assign pop_data_o = mem_q[rd_ptr_q];
    assign count_o    = count_q;
    assign empty_o    = (count_q == '0);

endmodule

// File: rtl/ibex_fetch_unit.sv
// ibex_fetch_unit
// Instruction fetch: computes redirect targets, issues word fetches on the
// instruction bus, buffers responses and hands them to ID.
// Optional build macro IBEX_FETCH_STAT_EN adds fetch_stall_cnt_o, a
// saturating count of cycles spent requesting without a grant.
// Ports:
//   clk_i, rst_ni          clock, async active-low reset
//   instr_req_i            controller allows new fetches
//   pc_set_i               redirect this cycle
//   pc_mux_i/exc_pc_mux_i  redirect target selects
//   exc_cause_i            IRQ vector index
//   boot_addr_i, jump_target_i, csr_mtvec_i, csr_mepc_i, csr_depc_i  target sources
//   instr_bus              instruction bus (master side)
//   id_in_ready_i          ID takes a new instruction
//   instr_valid_clear_i    ID drops its current instruction
//   instr_valid_id_o, instr_rdata_id_o, instr_fetch_err_o, pc_id_o  ID instruction
//   fetch_busy_o           requests outstanding or buffer non-empty
//
// state      | meaning
// FETCH_IDLE | no request on the bus (no permission or no free slot)
// FETCH_REQ  | request on the bus at fetch_addr, held until granted
module ibex_fetch_unit
    import ibex_pkg::*;
#(
    parameter int unsigned DEPTH        = 2,
    parameter logic [31:0] DM_HALT_ADDR = DM_HALT_ADDR_DEFAULT,
    parameter logic [31:0] DM_EXC_ADDR  = DM_EXC_ADDR_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        instr_req_i,
    input  logic        pc_set_i,
    input  logic [2:0]  pc_mux_i,
    input  logic [1:0]  exc_pc_mux_i,
    input  logic [5:0]  exc_cause_i,
    input  logic [31:0] boot_addr_i,
    input  logic [31:0] jump_target_i,
    input  logic [31:0] csr_mtvec_i,
    input  logic [31:0] csr_mepc_i,
    input  logic [31:0] csr_depc_i,
    ibex_fetch_unit_if.master instr_bus,
    input  logic        id_in_ready_i,
    input  logic        instr_valid_clear_i,
    output logic        instr_valid_id_o,
    output logic [31:0] instr_rdata_id_o,
    output logic        instr_fetch_err_o,
    output logic [31:0] pc_id_o,
    output logic        fetch_busy_o
`ifdef IBEX_FETCH_STAT_EN
    ,
    output logic [15:0] fetch_stall_cnt_o
`endif
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned OCC_W = CNT_W + 1;
    localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(DEPTH);

    fetch_state_e     state_q, state_d;
    logic [31:0]      fetch_addr_q, fetch_addr_d;
    logic [31:0]      resp_addr_q, resp_addr_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [CNT_W-1:0] discard_q, discard_d;

    logic [31:0]      exc_target, pc_target_raw, pc_target;
    logic             fetch_req, gnt_fire;
    logic [OCC_W-1:0] occ, occ_plus1, out_after_gnt;

    logic             fifo_push, fifo_pop, fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    fetch_entry_t     fifo_in, fifo_out;

    logic             unused_inputs;

    // Low bits replaced by fixed offsets in the target formulas.
    assign unused_inputs = ^{boot_addr_i[7:0], csr_mtvec_i[7:0], exc_cause_i[5]};

    always_comb begin
        exc_target = {csr_mtvec_i[31:8], 8'h00};
        case (exc_pc_sel_e'(exc_pc_mux_i))
            EXC_PC_EXC:     exc_target = {csr_mtvec_i[31:8], 8'h00};
            EXC_PC_IRQ:     exc_target = {csr_mtvec_i[31:8], 1'b0, exc_cause_i[4:0], 2'b00};
            EXC_PC_DBD:     exc_target = DM_HALT_ADDR;
            EXC_PC_DBG_EXC: exc_target = DM_EXC_ADDR;
            default:        exc_target = {csr_mtvec_i[31:8], 8'h00};
        endcase
    end

    always_comb begin
        pc_target_raw = {boot_addr_i[31:8], 8'h80};
        case (pc_sel_e'(pc_mux_i))
            PC_BOOT: pc_target_raw = {boot_addr_i[31:8], 8'h80};
            PC_JUMP: pc_target_raw = jump_target_i;
            PC_EXC:  pc_target_raw = exc_target;
            PC_ERET: pc_target_raw = csr_mepc_i;
            PC_DRET: pc_target_raw = csr_depc_i;
            // Unused encodings fall back to the boot target.
            default: pc_target_raw = {boot_addr_i[31:8], 8'h80};
        endcase
        pc_target = word_align(pc_target_raw);
    end

    assign fetch_req = (state_q == FETCH_REQ);
    assign gnt_fire  = fetch_req && instr_bus.gnt;

    // Each outstanding request or stored entry holds one FIFO slot. Discarded
    // requests are still counted, which only makes the reservation stricter.
    assign occ           = {1'b0, outstanding_q} + {1'b0, fifo_count};
    assign occ_plus1     = occ + OCC_W'(1);
    assign out_after_gnt = {1'b0, outstanding_q} + OCC_W'(gnt_fire);

    always_comb begin
        state_d      = state_q;
        fetch_addr_d = fetch_addr_q;
        case (state_q)
            FETCH_IDLE: begin
                if (instr_req_i && (occ < DEPTH_OCC)) begin
                    state_d = FETCH_REQ;
                end
            end
            FETCH_REQ: begin
                if (gnt_fire) begin
                    fetch_addr_d = fetch_addr_q + 32'd4;
                    if (!(instr_req_i && (occ_plus1 < DEPTH_OCC))) begin
                        state_d = FETCH_IDLE;
                    end
                end
            end
            default: state_d = FETCH_IDLE;
        endcase
        // Redirect replaces any pending ungranted request; the FIFO is empty
        // next cycle so only in-flight requests occupy slots.
        if (pc_set_i) begin
            fetch_addr_d = pc_target;
            state_d      = (instr_req_i && (out_after_gnt < DEPTH_OCC)) ? FETCH_REQ : FETCH_IDLE;
        end
    end

    always_comb begin
        outstanding_d = outstanding_q + CNT_W'(gnt_fire) - CNT_W'(instr_bus.rvalid);
        discard_d     = discard_q;
        resp_addr_d   = resp_addr_q;
        fifo_push     = 1'b0;
        if (pc_set_i) begin
            // Everything still in flight after this cycle belongs to the old
            // stream, including a response arriving right now.
            discard_d   = outstanding_d;
            resp_addr_d = pc_target;
        end else if (instr_bus.rvalid) begin
            if (discard_q != '0) begin
                discard_d = discard_q - CNT_W'(1);
            end else begin
                fifo_push   = 1'b1;
                resp_addr_d = resp_addr_q + 32'd4;
            end
        end
    end

    assign fifo_in  = '{rdata: instr_bus.rdata, err: instr_bus.err, pc: resp_addr_q};
    assign fifo_pop = id_in_ready_i && !fifo_empty && !pc_set_i;

    ibex_fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .flush_i     (pc_set_i),
        .push_i      (fifo_push),
        .push_data_i (fifo_in),
        .pop_i       (fifo_pop),
        .pop_data_o  (fifo_out),
        .count_o     (fifo_count),
        .empty_o     (fifo_empty)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= FETCH_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fetch_addr_q  <= '0;
            resp_addr_q   <= '0;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            fetch_addr_q  <= fetch_addr_d;
            resp_addr_q   <= resp_addr_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    // A pop presents a new instruction; clear only applies when nothing new arrives.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            instr_valid_id_o  <= 1'b0;
            instr_rdata_id_o  <= '0;
            instr_fetch_err_o <= 1'b0;
            pc_id_o           <= '0;
        end else if (fifo_pop) begin
            instr_valid_id_o  <= 1'b1;
            instr_rdata_id_o  <= fifo_out.rdata;
            instr_fetch_err_o <= fifo_out.err;
            pc_id_o           <= fifo_out.pc;
        end else if (pc_set_i || instr_valid_clear_i) begin
            instr_valid_id_o  <= 1'b0;
        end
    end

    assign instr_bus.req  = fetch_req;
    assign instr_bus.addr = fetch_addr_q;
    assign fetch_busy_o   = (outstanding_q != '0) || !fifo_empty;

`ifdef IBEX_FETCH_STAT_EN
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_q <= '0;
        end else if (fetch_req && !instr_bus.gnt && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign fetch_stall_cnt_o = stall_cnt_q;
`endif

endmodule
